// File: rtl/ram_dual_port_pipe.sv
// rtl/ram_dual_port_pipe.sv - simple dual-port RAM with read valid, optional output stage, bypass and post-reset clear
module ram_dual_port_pipe #(
    parameter int DATA_WIDTH    = 10,
    parameter int ADDRESS_WIDTH = 10,
    parameter int OUT_REG       = 0,
    parameter int BYPASS        = 1,
    parameter int INIT_CLEAR    = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we_a,
    input  logic [ADDRESS_WIDTH-1:0] addr_a,
    input  logic [DATA_WIDTH-1:0]    data_a,
    input  logic                     re_b,
    input  logic [ADDRESS_WIDTH-1:0] addr_b,
    output logic [DATA_WIDTH-1:0]    q_b,
    output logic                     q_valid_b,
    output logic                     init_busy
);

    localparam int DEPTH = 2 ** ADDRESS_WIDTH;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_CLEAR = 1'b1;

    logic [0:0]               state;
    logic [ADDRESS_WIDTH-1:0] clr_cnt;
    logic [DATA_WIDTH-1:0]    mem [0:DEPTH-1];

    logic                     clr_wr;
    logic                     wr_qual;
    logic                     rd_issue;
    logic                     bypass_hit;

    logic [DATA_WIDTH-1:0]    s1_data;
    logic                     s1_valid;

    assign init_busy  = (state == S_CLEAR);
    assign clr_wr     = init_busy & ~rst;
    assign wr_qual    = we_a & ~init_busy & ~rst;
    assign rd_issue   = re_b & ~init_busy & ~rst;
    assign bypass_hit = (BYPASS != 0) && wr_qual && (addr_a == addr_b);

    // Clear sequencer: reset (re)starts a sweep from address 0 that walks the whole array once
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= (INIT_CLEAR != 0) ? S_CLEAR : S_IDLE;
            clr_cnt <= '0;
        end else if (state == S_CLEAR) begin
            clr_cnt <= clr_cnt + ADDRESS_WIDTH'(1);
            if (&clr_cnt) begin
                state <= S_IDLE;
            end
        end
    end

    // Single array write port, shared by the clear sweep and port A; the sweep blocks port A
    always_ff @(posedge clk) begin
        if (clr_wr) begin
            mem[clr_cnt] <= '0;
        end else if (wr_qual) begin
            mem[addr_a] <= data_a;
        end
    end

    // Stage 1: registered array read, with optional same-address forwarding of the write data
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_data  <= '0;
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= rd_issue;
            if (rd_issue) begin
                s1_data <= bypass_hit ? data_a : mem[addr_b];
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_WIDTH-1:0] s2_data;
            logic                  s2_valid;

            // Stage 2: unconditional copy of stage 1 to ease timing on the read path
            always_ff @(posedge clk) begin
                if (rst) begin
                    s2_data  <= '0;
                    s2_valid <= 1'b0;
                end else begin
                    s2_data  <= s1_data;
                    s2_valid <= s1_valid;
                end
            end

            assign q_b       = s2_data;
            assign q_valid_b = s2_valid;
        end else begin : g_no_out_reg
            assign q_b       = s1_data;
            assign q_valid_b = s1_valid;
        end
    endgenerate

endmodule

// File: doc/ram_dual_port_pipe.md
Name: ram_dual_port_pipe

Overview:
- Parametrised simple-dual-port RAM: one write port (A), one read port (B).
- Successor to the basic alpha-buffer RAM. Adds:
  - synchronous reset
  - read enable with valid flag
  - optional output pipeline register
  - same-address write-to-read bypass
  - post-reset memory clear sequencer
- Used as the line/alpha buffer in video blend pipelines where deterministic startup contents and a registered output are required.

Parameters:
- DATA_WIDTH, 10, width of each word in bits.
- ADDRESS_WIDTH, 10, address bits; depth = 2**ADDRESS_WIDTH.
- OUT_REG, 0, 1 = extra output register stage. Read latency is 1+OUT_REG.
- BYPASS, 1, 1 = a same-cycle write to the read address is forwarded to the read data (write-first). 0 = old data (read-first).
- INIT_CLEAR, 1, 1 = zero the whole array after every reset.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  synchronous, active-high reset.
- we_a  in  1  write enable, port A.
- addr_a  in  ADDRESS_WIDTH  write address.
- data_a  in  DATA_WIDTH  write data.
- re_b  in  1  read enable, port B.
- addr_b  in  ADDRESS_WIDTH  read address.
- q_b  out  DATA_WIDTH  read data (registered).
- q_valid_b  out  1  q_b carries the result of a read issued 1+OUT_REG cycles earlier.
- init_busy  out  1  clear sequence in progress; port A writes and port B reads are ignored.

Behaviour:

Reset values (cycle after rst sampled high):
- q_b = 0
- q_valid_b = 0
- pipeline valid bits = 0
- init_busy = INIT_CLEAR
- clear counter = 0

Array contents are not reset by rst itself.

Clear FSM (states IDLE, CLEAR), only when INIT_CLEAR=1:
- rst forces CLEAR with counter = 0.
- In CLEAR:
  - writes 0 to mem[counter] each cycle, then increments the counter.
  - when counter = depth-1 is written, goes to IDLE.
  - init_busy is high for exactly depth cycles after rst deasserts, then falls.
- In IDLE:
  - init_busy = 0; normal operation.
- rst asserted mid-CLEAR restarts the clear from address 0.
- When INIT_CLEAR=0: the FSM stays in IDLE and init_busy is constant 0.

Write port:
- mem[addr_a] <= data_a on each rising edge where we_a=1 and init_busy=0.
- Writes while init_busy=1 are dropped; there is no back-pressure.

Read port:
- A read is issued on an edge where re_b=1, init_busy=0 and rst=0.
- Stage 1: the read data register loads mem[addr_b].
  - If BYPASS=1 and the same edge has a qualified write with addr_a==addr_b, it loads data_a instead.
  - If BYPASS=0, it loads the pre-write contents.
- OUT_REG=0:
  - q_b = stage-1 register.
  - q_valid_b = 1 in the cycle after issue.
- OUT_REG=1:
  - stage 2 copies stage 1 (data and valid) every cycle.
  - q_b and q_valid_b come from stage 2; latency is 2.
- When no read is issued:
  - stage-1 data holds its previous value.
  - stage-1 valid = 0.
  - q_b therefore holds the last read value while q_valid_b is 0.
- Back-to-back reads give one result per cycle, in issue order, with no bubbles.

Boundary cases:
- Address wrap: addresses are modulo depth; there is no range checking.
- Simultaneous rst with we_a/re_b: rst wins; the write is dropped and no read is issued.
- Read of an address written N cycles earlier (N>=1): returns the new data regardless of BYPASS.
- Before any write, with INIT_CLEAR=1: reads return 0 after init_busy falls.

Inference:
- The memory must infer a single LSRAM block.
- The bypass mux and the clear counter sit outside the array; the array itself has one write port and one read port.

Test Plan:
- Clear sequence (ADDRESS_WIDTH=4, INIT_CLEAR=1):
  - Pulse rst for 1 cycle -> init_busy high for exactly 16 cycles after release.
  - Then read addresses 0..15 -> all q_b=0, each with q_valid_b=1 one cycle after re_b.
- Reset mid-clear:
  - Assert rst when the counter is 9 -> init_busy stays high 16 more cycles after release.
  - Writes to addr 3 during busy (data 0x155) are dropped; a later read of addr 3 returns 0.
- Latency and streaming (OUT_REG=0, then OUT_REG=1):
  - Write 0x001..0x008 to addr 0..7, then read addr 0..7 back-to-back.
  - Required: data in order with no gaps, first valid 1 or 2 cycles after the first re_b respectively.
  - q_b holds 0x008 after re_b drops, with q_valid_b=0.
- Collision:
  - addr 5 holds 0x0AA; same edge: we_a=1, addr_a=5, data_a=0x3FF, re_b=1, addr_b=5.
  - BYPASS=1 -> q_b=0x3FF. BYPASS=0 -> q_b=0x0AA.
  - Next-cycle read -> 0x3FF in both cases.
- Wrap and priority:
  - Write 0x2A5 to addr 15, read addr 15 -> q_b=0x2A5.
  - Assert rst together with re_b -> q_valid_b stays 0 and q_b=0 next cycle.
- INIT_CLEAR=0:
  - init_busy is never high.
  - Write addr 2 = 0x111 in the first cycle after reset and read it back the next cycle -> 0x111.
